// File: rtl/fetch_buffer.sv
// Instruction fetch stage: sequences the PC, drives the imem read handshake and
// buffers returned words for decode; redirects from write flush and restart fetch.

// Generic synchronous FIFO with flush; head entry is read combinationally.
// Latency 1 cycle push to head; a pop in the same cycle frees a slot for a push into a full FIFO.
module fetch_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     i_flush,
    input  logic                     i_push_vld,
    input  logic [W-1:0]             i_push_dat,
    input  logic                     i_pop_rdy,
    output logic [W-1:0]             o_head_dat,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign o_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = i_pop_rdy && !o_empty;
    assign w_push     = i_push_vld && (!w_full || w_pop);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// Fetch stage top: issues reads at fetch_pc, pushes returned words tagged with PC and flush flag.
// Latency data_valid -> out_valid 1 cycle; stops requesting when the buffer would be full, hold stalls the head.
module fetch_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        address_enable,
    output logic [31:0] address,
    input  logic [31:0] data,
    input  logic        data_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] next_pc,
    input  logic        hold,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        out_has_flushed
);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQUEST = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        flushed;
    } entry_t;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_discard_addr;
    logic          r_flush_pending;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_after;
    entry_t        w_push_dat;
    entry_t        w_head;

    assign w_push     = (r_state == S_REQUEST) && data_valid && !redirect_valid;
    assign w_pop      = !w_empty && !hold && !redirect_valid;
    assign w_push_dat = '{insn: data, pc: r_fetch_pc, flushed: r_flush_pending};
    assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);

    fetch_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_flush    (redirect_valid),
        .i_push_vld (w_push),
        .i_push_dat (w_push_dat),
        .i_pop_rdy  (w_pop),
        .o_head_dat (w_head),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (redirect_valid || (w_count < CW'(DEPTH))) begin
                    w_state_nxt = S_REQUEST;
                end
            end
            S_REQUEST: begin
                // A request cannot be withdrawn, so a redirect without its response must wait it out.
                if (redirect_valid) begin
                    w_state_nxt = data_valid ? S_REQUEST : S_DISCARD;
                end else if (data_valid) begin
                    w_state_nxt = (w_count_after < CW'(DEPTH)) ? S_REQUEST : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (data_valid) begin
                    w_state_nxt = S_REQUEST;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_fetch_pc      <= RESET_PC;
            r_flush_pending <= 1'b0;
            r_discard_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid) begin
                r_fetch_pc      <= redirect_pc;
                r_flush_pending <= 1'b1;
            end else if (w_push) begin
                r_fetch_pc      <= r_fetch_pc + 32'(PC_STEP);
                r_flush_pending <= 1'b0;
            end
            if ((r_state == S_REQUEST) && redirect_valid && !data_valid) begin
                r_discard_addr <= r_fetch_pc;
            end
        end
    end

    assign address_enable  = (r_state == S_REQUEST) || (r_state == S_DISCARD);
    assign address         = (r_state == S_REQUEST) ? r_fetch_pc :
                             (r_state == S_DISCARD) ? r_discard_addr : 32'h0;
    assign out_valid       = !w_empty;
    assign out_instruction = out_valid ? w_head.insn : 32'h0;
    assign out_pc          = out_valid ? w_head.pc : 32'h0;
    assign out_has_flushed = out_valid && w_head.flushed;
    assign next_pc         = out_valid ? w_head.pc : r_fetch_pc;
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fetch_buffer;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        address_enable;
    logic [31:0] address;
    logic [31:0] data;
    logic        data_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] next_pc;
    logic        hold;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_has_flushed;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(4)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .address_enable  (address_enable),
        .address         (address),
        .data            (data),
        .data_valid      (data_valid),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .next_pc         (next_pc),
        .hold            (hold),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_has_flushed (out_has_flushed)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        fl;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_exp_addr;
    logic        m_flush;
    logic        m_stale;
    logic        prev_pending;
    logic [31:0] prev_addr;
    int          idle_run;
    int          age;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        q.delete();
        m_exp_addr   = RESET_PC;
        m_flush      = 1'b0;
        m_stale      = 1'b0;
        prev_pending = 1'b0;
        prev_addr    = '0;
        idle_run     = 0;
        age          = 0;
    endtask

    // Compare outputs with the model, then advance the model by this cycle's events.
    task automatic observe();
        bit          nonempty;
        bit          pop;
        exp_t        e;
        nonempty = (q.size() != 0);
        check("out_valid", 32'(out_valid), 32'(nonempty));
        if (nonempty) begin
            check("out_pc", out_pc, q[0].pc);
            check("out_instruction", out_instruction, q[0].insn);
            check("out_has_flushed", 32'(out_has_flushed), 32'(q[0].fl));
        end
        check("next_pc", next_pc, nonempty ? q[0].pc : m_exp_addr);
        if (prev_pending) begin
            check("ae_held", 32'(address_enable), 32'd1);
            check("addr_held", address, prev_addr);
        end
        if (address_enable && !m_stale) check("address", address, m_exp_addr);
        if (q.size() == DEPTH) check("ae_when_full", 32'(address_enable), 32'd0);
        idle_run = (!address_enable && q.size() < DEPTH) ? idle_run + 1 : 0;
        check("ae_not_starved", 32'(idle_run > 1), 32'd0);

        pop          = nonempty && !hold && !redirect_valid;
        prev_pending = address_enable && !data_valid;
        prev_addr    = address;
        age          = (address_enable && !data_valid) ? age + 1 : 0;
        if (redirect_valid) begin
            q.delete();
            m_exp_addr = redirect_pc;
            m_flush    = 1'b1;
            m_stale    = address_enable && !data_valid;
        end else begin
            if (pop) void'(q.pop_front());
            if (address_enable && data_valid) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    e.insn = mem_word(m_exp_addr);
                    e.pc   = m_exp_addr;
                    e.fl   = m_flush;
                    q.push_back(e);
                    m_flush    = 1'b0;
                    m_exp_addr = m_exp_addr + 32'd4;
                end
            end
        end
    endtask

    task automatic drive_mem(input int lat);
        if (address_enable && age >= lat) begin
            data_valid = 1'b1;
            data       = mem_word(address);
        end else begin
            data_valid = 1'b0;
            data       = $urandom();
        end
    endtask

    task automatic run_cycle(input int lat);
        drive_mem(lat);
        @(negedge clock);
        observe();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        data_valid     = 1'b0;
        redirect_valid = 1'b0;
        hold           = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] seen [2];
        int          nseen;
        reset_n        = 1'b0;
        data           = '0;
        data_valid     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        hold           = 1'b0;
        model_reset();
        #12;
        check("rst_ae", 32'(address_enable), 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_next_pc", next_pc, RESET_PC);

        // Sequential fetch with single-cycle memory
        do_reset();
        repeat (12) run_cycle(1);

        // Decode stalled: buffer fills and fetch idles
        do_reset();
        hold = 1'b1;
        repeat (8) run_cycle(1);
        check("hold_ae_idle", 32'(address_enable), 32'd0);
        check("hold_head_pc", out_pc, 32'd0);
        check("hold_next_pc", next_pc, 32'd0);
        hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_cycle(1);
            if (address_enable) break;
        end
        check("after_hold_addr", address, 32'd8);

        // Redirect with the request at 8 still outstanding
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        run_cycle(1);
        redirect_valid = 1'b0;
        check("discard_ae", 32'(address_enable), 32'd1);
        check("discard_addr", address, 32'd8);
        for (int i = 0; i < 8; i++) begin
            run_cycle(1);
            if (address_enable && address == 32'h100) break;
        end
        check("redir_addr", address, 32'h100);
        for (int i = 0; i < 8; i++) begin
            if (out_valid) break;
            run_cycle(1);
        end
        check("redir_first_pc", out_pc, 32'h100);
        check("redir_first_flushed", 32'(out_has_flushed), 32'd1);
        run_cycle(1);
        for (int i = 0; i < 8; i++) begin
            if (out_valid) break;
            run_cycle(1);
        end
        check("redir_second_pc", out_pc, 32'h104);
        check("redir_second_flushed", 32'(out_has_flushed), 32'd0);

        // Redirect in the same cycle as the memory response
        for (int i = 0; i < 8; i++) begin
            if (address_enable && age >= 1) break;
            run_cycle(1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        run_cycle(1);
        redirect_valid = 1'b0;
        check("rdv_empty", 32'(out_valid), 32'd0);
        check("rdv_next_pc", next_pc, 32'h2000);
        check("rdv_ae", 32'(address_enable), 32'd1);
        check("rdv_addr", address, 32'h2000);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        run_cycle(1);
        redirect_valid = 1'b0;
        nseen = 0;
        seen[0] = 32'hDEAD_BEEF;
        seen[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            run_cycle(1);
            if (out_valid && nseen < 2) begin
                seen[nseen] = out_pc;
                nseen++;
            end
        end
        check("wrap_first", seen[0], 32'hFFFF_FFFC);
        check("wrap_second", seen[1], 32'h0);

        // Reset while a request is outstanding and one entry is buffered
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1);
            if (out_valid) break;
        end
        check("pre_rst_ae", 32'(address_enable), 32'd1);
        reset_n    = 1'b0;
        data_valid = 1'b1;
        data       = 32'hCAFE_F00D;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ae", 32'(address_enable), 32'd0);
        check("mid_rst_out_pc", out_pc, 32'd0);
        check("mid_rst_out_insn", out_instruction, 32'd0);
        check("mid_rst_next_pc", next_pc, RESET_PC);
        repeat (2) @(posedge clock);
        #1;
        data_valid = 1'b0;
        hold       = 1'b0;
        model_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_cycle(1);
            if (out_valid) break;
        end
        check("post_rst_pc", out_pc, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            hold           = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFF8;
                1:       redirect_pc = 32'hFFFF_FFFC;
                default: redirect_pc = $urandom() & 32'hFFFF_FFFC;
            endcase
            if ($urandom_range(0, 499) == 0) do_reset();
            else run_cycle(int'($urandom_range(0, 3)));
        end
        redirect_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
